multi_string_matcher: RTL and testbench
=======================================

MULTI_STRING_MATCHER -- requirements
Module: multi_string_matcher

Interface
REQ-001 Parameter NUM_PATTERNS, default 4: number of independently programmable flagged strings.
REQ-002 Parameter MAX_LEN, default 17: maximum pattern length in bytes.
REQ-003 Parameter BYTES_PER_BEAT, default 4: stream bytes per beat; DW = 8*BYTES_PER_BEAT.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 clear  in  1  synchronous flush of window, match state, counter and output stage.
REQ-007 cfg_we  in  1  pattern write strobe.
REQ-008 cfg_sel  in  $clog2(NUM_PATTERNS)  pattern slot addressed by cfg_we.
REQ-009 cfg_len  in  $clog2(MAX_LEN+1)  pattern length in bytes; 0 disables the slot.
REQ-010 cfg_string  in  8*MAX_LEN  pattern bytes; bits [7:0] hold the first character.
REQ-011 data_valid  in  1  qualifies data_in; a beat is accepted on any edge where data_valid=1 and clear=0.
REQ-012 data_in  in  DW  stream beat; bits [DW-1:DW-8] carry the earliest byte.
REQ-013 data_out  out  DW  registered copy of the last accepted beat.
REQ-014 data_out_valid  out  1  high for one cycle after each accepted beat.
REQ-015 match  out  1  sticky: any pattern has matched since reset/clear.
REQ-016 match_hit  out  NUM_PATTERNS  sticky per-slot match flags.
REQ-017 match_count  out  8  number of accepted beats completing at least one match; saturates at 255.

Function
REQ-018 The block SHALL keep a byte window of the last MAX_LEN-1 accepted bytes plus a per-byte valid bit; never-received bytes SHALL never compare equal.
REQ-019 On each accepted beat, each enabled slot SHALL be tested for a match ending at every one of the BYTES_PER_BEAT byte positions of the current beat, using window bytes for earlier characters.
REQ-020 Matches SHALL span beat boundaries; beats with data_valid=0 SHALL NOT shift the window or break a spanning match.
REQ-021 Latency: match, match_hit and match_count SHALL reflect a beat in the cycle after the edge at which it is accepted.
REQ-022 data_out/data_out_valid SHALL have one-cycle latency; data_out SHALL hold its value while data_out_valid=0.
REQ-023 Slots with cfg_len=0 or cfg_len>MAX_LEN SHALL be disabled and never match.
REQ-024 A cfg_we write SHALL take effect for beats accepted after that edge; a beat accepted on the same edge SHALL compare against the old pattern.
REQ-025 Multiple slots matching on one beat SHALL set all their match_hit bits and increment match_count by exactly 1.
REQ-026 clear SHALL take priority over data_valid (the beat is dropped); clear SHALL NOT alter programmed patterns; cfg_we on the same edge SHALL still be applied.
REQ-027 match_count SHALL hold at 255 once reached, until reset or clear.

Reset
REQ-028 n_rst low SHALL immediately zero the window, valid bits, data_out, data_out_valid, match, match_hit, match_count and all pattern lengths (all slots disabled).
REQ-029 Reset asserted mid-pattern SHALL discard all partial-match history; the first post-reset beat starts a fresh window.

Configuration
REQ-030 Macro CASE_FOLD_EN defined: ASCII 0x41-0x5A in both stream bytes and pattern bytes SHALL be folded to 0x61-0x7A before comparison; data_out SHALL remain unfolded.
REQ-031 Macro CASE_FOLD_EN undefined: comparison SHALL be exact byte equality, with no folding logic.

Verification (NUM_PATTERNS=4, MAX_LEN=17, BYTES_PER_BEAT=4)
REQ-032 Slot 0 = "EVIL" (len 4); accept 0x4556494C -> next cycle match=1, match_hit=4'b0001, match_count=1, data_out=0x4556494C.
REQ-033 Slot 1 = "ABCDEF"; accept 0x78784142, two idle cycles, then 0x43444546 -> match_hit[1]=1 only after the second beat.
REQ-034 Slot 2 = 17-byte "0123456789ABCDEFG"; stream it over 5 beats offset by 3 leading pad bytes -> match_hit[2]=1 after beat 5, not earlier.
REQ-035 Slot 0 = "EVIL"; accept 0x00004556, pulse clear, accept 0x494C0000 -> match=0, match_count=0.
REQ-036 Slot 0 = "evil"; accept 0x4556494C -> match=1 with CASE_FOLD_EN, match=0 without.
REQ-037 Slots 0 and 3 both "AAAA"; accept 0x41414141 for 300 beats -> match_hit=4'b1001, match_count saturates at 255; n_rst mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/multi_string_matcher.sv
// Streaming multi-pattern byte matcher: programmable slots tested at every byte lane of each beat.
// Optional build macro CASE_FOLD_EN folds ASCII upper case to lower case before comparison.
module multi_string_matcher #(
    parameter int unsigned NUM_PATTERNS   = 4,
    parameter int unsigned MAX_LEN        = 17,
    parameter int unsigned BYTES_PER_BEAT = 4
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              clear,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_PATTERNS)-1:0]   cfg_sel,
    input  logic [$clog2(MAX_LEN+1)-1:0]      cfg_len,
    input  logic [8*MAX_LEN-1:0]              cfg_string,
    input  logic                              data_valid,
    input  logic [8*BYTES_PER_BEAT-1:0]       data_in,
    output logic [8*BYTES_PER_BEAT-1:0]       data_out,
    output logic                              data_out_valid,
    output logic                              match,
    output logic [NUM_PATTERNS-1:0]           match_hit,
    output logic [7:0]                        match_count
);

    localparam int unsigned DW  = 8 * BYTES_PER_BEAT;
    localparam int unsigned WIN = MAX_LEN - 1;
    localparam int unsigned TOT = WIN + BYTES_PER_BEAT;
    localparam int unsigned LW  = $clog2(MAX_LEN + 1);

    logic [8*WIN-1:0]     win_bytes;
    logic [WIN-1:0]       win_valid;
    logic [8*TOT-1:0]     cat_bytes;
    logic [TOT-1:0]       cat_valid;
    logic [NUM_PATTERNS-1:0] hit_vec;
    logic                 beat_hit;
    logic [LW-1:0]        pat_len [NUM_PATTERNS];
    logic [8*MAX_LEN-1:0] pat_str [NUM_PATTERNS];

`ifdef CASE_FOLD_EN
    function automatic logic [7:0] fold(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) ? (b | 8'h20) : b;
    endfunction
`else
    function automatic logic [7:0] fold(input logic [7:0] b);
        return b;
    endfunction
`endif

    // True when the slot's pattern ends exactly at byte index p of the concatenated window+beat.
    function automatic logic end_match(input logic [8*TOT-1:0] cb,
                                       input logic [TOT-1:0]   cv,
                                       input logic [8*MAX_LEN-1:0] pstr,
                                       input logic [LW-1:0]    plen,
                                       input int unsigned      p);
        logic            ok;
        int unsigned     l;
        int unsigned     q;
        logic [TOT-1:0]  vs;
        logic [8*TOT-1:0] bs;
        l  = 32'(plen);
        ok = (l != 0) && (l <= MAX_LEN);
        if (ok) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                if (k < l) begin
                    q  = p + 1 + k - l;
                    vs = cv >> q;
                    bs = cb >> (8 * q);
                    if (!vs[0] || (fold(bs[7:0]) != fold(pstr[8*k +: 8])))
                        ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // Oldest window byte at index 0; beat bytes appended earliest-first.
    always_comb begin
        cat_bytes = '0;
        cat_bytes[8*WIN-1:0] = win_bytes;
        for (int unsigned j = 0; j < BYTES_PER_BEAT; j++)
            cat_bytes[8*(WIN+j) +: 8] = data_in[DW-1-8*j -: 8];
        cat_valid = {{BYTES_PER_BEAT{1'b1}}, win_valid};
    end

    always_comb begin
        hit_vec = '0;
        for (int unsigned s = 0; s < NUM_PATTERNS; s++)
            for (int unsigned j = 0; j < BYTES_PER_BEAT; j++)
                if (end_match(cat_bytes, cat_valid, pat_str[s], pat_len[s], WIN + j))
                    hit_vec[s] = 1'b1;
        beat_hit = |hit_vec;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_bytes      <= '0;
            win_valid      <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            match          <= 1'b0;
            match_hit      <= '0;
            match_count    <= '0;
            for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
                pat_len[i] <= '0;
                pat_str[i] <= '0;
            end
        end else begin
            // Pattern writes land regardless of clear; same-edge beats see the old pattern.
            if (cfg_we) begin
                pat_len[cfg_sel] <= cfg_len;
                pat_str[cfg_sel] <= cfg_string;
            end
            if (clear) begin
                win_bytes      <= '0;
                win_valid      <= '0;
                data_out       <= '0;
                data_out_valid <= 1'b0;
                match          <= 1'b0;
                match_hit      <= '0;
                match_count    <= '0;
            end else begin
                data_out_valid <= data_valid;
                if (data_valid) begin
                    win_bytes <= cat_bytes[8*TOT-1 -: 8*WIN];
                    win_valid <= cat_valid[TOT-1 -: WIN];
                    data_out  <= data_in;
                    match_hit <= match_hit | hit_vec;
                    if (beat_hit) begin
                        match <= 1'b1;
                        if (match_count != 8'hFF)
                            match_count <= match_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_string_matcher.sv
// Directed bench for multi_string_matcher (default parameters); honours CASE_FOLD_EN if defined.
module tb_multi_string_matcher;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         cfg_we;
    logic [1:0]   cfg_sel;
    logic [4:0]   cfg_len;
    logic [135:0] cfg_string;
    logic         data_valid;
    logic [31:0]  data_in;
    logic [31:0]  data_out;
    logic         data_out_valid;
    logic         match;
    logic [3:0]   match_hit;
    logic [7:0]   match_count;

    int checks   = 0;
    int failures = 0;

`ifdef CASE_FOLD_EN
    localparam logic FOLD = 1'b1;
`else
    localparam logic FOLD = 1'b0;
`endif

    multi_string_matcher dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .cfg_we         (cfg_we),
        .cfg_sel        (cfg_sel),
        .cfg_len        (cfg_len),
        .cfg_string     (cfg_string),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .match          (match),
        .match_hit      (match_hit),
        .match_count    (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [135:0] mkpat(input string s);
        logic [135:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++)
            r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [4:0] len, input string s);
        cfg_we = 1'b1; cfg_sel = sel; cfg_len = len; cfg_string = mkpat(s);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        data_valid = 1'b1; data_in = d;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_len = '0;
        cfg_string = '0; data_valid = 1'b0; data_in = '0;
        #12;
        chk("rst_match", 64'(match), 64'd0);
        chk("rst_hit", 64'(match_hit), 64'd0);
        chk("rst_count", 64'(match_count), 64'd0);
        chk("rst_dov", 64'(data_out_valid), 64'd0);
        chk("rst_dout", 64'(data_out), 64'd0);
        n_rst = 1'b1;

        // Single-beat match
        cfg(2'd0, 5'd4, "EVIL");
        beat(32'h4556494C);
        chk("evil_match", 64'(match), 64'd1);
        chk("evil_hit", 64'(match_hit), 64'b0001);
        chk("evil_count", 64'(match_count), 64'd1);
        chk("evil_dout", 64'(data_out), 64'h4556494C);
        chk("evil_dov", 64'(data_out_valid), 64'd1);
        tick();
        chk("idle_dov", 64'(data_out_valid), 64'd0);
        chk("idle_dout_hold", 64'(data_out), 64'h4556494C);

        // Match spanning beats across idle cycles
        do_clear();
        chk("clr_count", 64'(match_count), 64'd0);
        cfg(2'd1, 5'd6, "ABCDEF");
        beat(32'h78784142);
        chk("span_first_hit", 64'(match_hit), 64'b0000);
        tick(); tick();
        beat(32'h43444546);
        chk("span_hit", 64'(match_hit), 64'b0010);
        chk("span_count", 64'(match_count), 64'd1);

        // Max-length pattern over 5 beats; slot 1 disabled by oversize length
        do_clear();
        cfg(2'd1, 5'd18, "ABCDEF");
        cfg(2'd2, 5'd17, "0123456789ABCDEFG");
        beat(32'h2E2E2E30);
        beat(32'h31323334);
        tick();
        beat(32'h35363738);
        beat(32'h39414243);
        chk("long_b4_hit", 64'(match_hit), 64'b0000);
        beat(32'h44454647);
        chk("long_b5_hit", 64'(match_hit), 64'b0100);
        chk("long_b5_count", 64'(match_count), 64'd1);

        // Clear between halves breaks the match
        do_clear();
        beat(32'h00004556);
        do_clear();
        chk("clr_dov", 64'(data_out_valid), 64'd0);
        chk("clr_dout", 64'(data_out), 64'd0);
        beat(32'h494C0000);
        chk("clr_split_match", 64'(match), 64'd0);
        chk("clr_split_count", 64'(match_count), 64'd0);

        // Clear wins over a same-edge beat
        clear = 1'b1; data_valid = 1'b1; data_in = 32'h4556494C;
        tick();
        clear = 1'b0; data_valid = 1'b0;
        chk("clr_prio_match", 64'(match), 64'd0);
        chk("clr_prio_dov", 64'(data_out_valid), 64'd0);

        // Same-edge config write: beat still sees old "EVIL"
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_len = 5'd4; cfg_string = mkpat("evil");
        data_valid = 1'b1; data_in = 32'h4556494C;
        tick();
        cfg_we = 1'b0; data_valid = 1'b0;
        chk("cfg_same_edge", 64'(match), 64'd1);

        // Case folding against lower-case pattern
        do_clear();
        beat(32'h4556494C);
        chk("fold_match", 64'(match), 64'(FOLD));
        chk("fold_dout", 64'(data_out), 64'h4556494C);

        // Two slots on one beat; saturation
        do_clear();
        cfg(2'd0, 5'd4, "AAAA");
        cfg(2'd3, 5'd4, "AAAA");
        for (int i = 0; i < 300; i++) begin
            beat(32'h41414141);
            if (i == 0) begin
                chk("dual_hit", 64'(match_hit), 64'b1001);
                chk("dual_count", 64'(match_count), 64'd1);
            end
            if (i == 253) chk("count_254", 64'(match_count), 64'd254);
            if (i == 254) chk("count_255", 64'(match_count), 64'd255);
        end
        chk("count_sat", 64'(match_count), 64'd255);

        // Asynchronous reset mid-stream
        data_valid = 1'b1; data_in = 32'h78784556;
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_match", 64'(match), 64'd0);
        chk("arst_hit", 64'(match_hit), 64'd0);
        chk("arst_count", 64'(match_count), 64'd0);
        chk("arst_dov", 64'(data_out_valid), 64'd0);
        chk("arst_dout", 64'(data_out), 64'd0);
        data_valid = 1'b0;
        #3;
        n_rst = 1'b1;
        beat(32'h41414141);
        chk("arst_slots_off", 64'(match), 64'd0);
        cfg(2'd0, 5'd4, "EVIL");
        beat(32'h494C0000);
        chk("arst_fresh_window", 64'(match), 64'd0);
        beat(32'h4556494C);
        chk("post_rst_match", 64'(match), 64'd1);
        chk("post_rst_count", 64'(match_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
